// File: rtl/addsub_seq.sv
// addsub_seq: multi-cycle adder/subtractor that handles C bits per clock,
// least-significant chunk first, over N = W/C BUSY cycles.
// Handshake: operands are taken on in_valid && in_ready (IDLE only).
// The result is held while out_valid is high (DONE) until out_ready.
// W must be an integer multiple of C, with 1 <= C <= W.
// Optional feature: define ADDSUB_SAT_EN to saturate the presented result
// on two's-complement overflow. Without the macro, the result wraps and no
// saturation logic is built.
module addsub_seq #(
  parameter int W = 8,
  parameter int C = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] y,
  output logic         cout,
  output logic         ovf,
  output logic         zero,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int N  = W / C;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic          sub_r;
  logic          carry;
  logic [CW-1:0] cnt;

  logic [W-1:0]  y_r;
  logic          cout_r;
  logic          ovf_r;
  logic          zero_r;

  logic [C-1:0]  a_chunk;
  logic [C-1:0]  b_chunk;
  logic [C-1:0]  s_chunk;
  logic          c_chunk;
  logic          last;
  logic          cin_msb;
  logic          ovf_now;
  logic [W-1:0]  y_ins;
  logic [W-1:0]  y_fin;

  // State register; reset drops any operation in flight back to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // One chunk of the ripple: a chunk plus the (optionally inverted) b chunk
  // plus the running carry. The carry into the word MSB is recovered from the
  // sum bit, so overflow works even when a chunk is a single bit wide.
  always_comb begin
    a_chunk = a_r[cnt*C +: C];
    b_chunk = sub_r ? ~b_r[cnt*C +: C] : b_r[cnt*C +: C];
    {c_chunk, s_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{C{1'b0}}, carry};
    last    = (cnt == CW'(N - 1));
    cin_msb = s_chunk[C-1] ^ a_chunk[C-1] ^ b_chunk[C-1];
    ovf_now = cin_msb ^ c_chunk;
    y_ins   = y_r;
    y_ins[cnt*C +: C] = s_chunk;
    y_fin   = y_ins;
`ifdef ADDSUB_SAT_EN
    if (ovf_now) begin
      y_fin = a_r[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
`endif
  end

  // Operand capture, chunk sequencing and result/flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      sub_r  <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
      y_r    <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      zero_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            sub_r <= sub;
            carry <= sub;
            cnt   <= '0;
          end
        end
        BUSY: begin
          carry <= c_chunk;
          if (last) begin
            cnt    <= '0;
            y_r    <= y_fin;
            cout_r <= c_chunk;
            ovf_r  <= ovf_now;
            zero_r <= (y_fin == '0);
          end else begin
            cnt <= cnt + CW'(1);
            y_r <= y_ins;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign y    = y_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;
  assign zero = zero_r;

endmodule

// File: doc/addsub_seq.md
ADDSUB_SEQ -- requirements
Module: addsub_seq

Interface
REQ-001 SHALL have parameter W, default 8: operand/result width in bits.
REQ-002 SHALL have parameter C, default 2: bits processed per cycle; W SHALL be an integer multiple of C, 1 <= C <= W.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port a  input  W  first operand.
REQ-006 SHALL have port b  input  W  second operand.
REQ-007 SHALL have port sub  input  1  1 = a-b, 0 = a+b.
REQ-008 SHALL have port in_valid  input  1  operands valid.
REQ-009 SHALL have port in_ready  output  1  block can accept operands.
REQ-010 SHALL have port y  output  W  result.
REQ-011 SHALL have port cout  output  1  carry out of MSB (for subtract, 1 = no borrow).
REQ-012 SHALL have port ovf  output  1  two's-complement overflow.
REQ-013 SHALL have port zero  output  1  y == 0.
REQ-014 SHALL have port out_valid  output  1  result valid.
REQ-015 SHALL have port out_ready  input  1  consumer accepts result.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-017 SHALL accept operands on a rising edge where in_valid && in_ready: register a, b, sub; carry register := sub; chunk counter := 0; go to BUSY.
REQ-018 SHALL, each BUSY cycle, add C-bit chunk k of a and of (sub ? ~b : b) plus carry register, writing C result bits to y[k*C +: C] and the chunk carry back to the carry register, LSB chunk first.
REQ-019 SHALL leave BUSY for DONE after exactly N = W/C BUSY cycles; out_valid SHALL rise N+1 edges after the accepting edge (C = W gives 1-cycle BUSY).
REQ-020 SHALL set cout to the final chunk carry and ovf to carry-into-MSB XOR carry-out-of-MSB, both registered on entry to DONE.
REQ-021 SHALL compute zero from the final y presented in DONE.
REQ-022 SHALL hold y, cout, ovf, zero stable in DONE until out_valid && out_ready, then go to IDLE; outputs keep last values in IDLE and BUSY but are only meaningful while out_valid = 1.
REQ-023 SHALL ignore changes on a, b, sub, in_valid outside the accepting edge; in_valid in BUSY/DONE SHALL not be accepted (no overlap; throughput at most one op per N+2 cycles with out_ready held 1).
REQ-024 SHALL result equal (a + b) mod 2^W or (a - b) mod 2^W for all operand values, identical to a single-cycle add/sub of width W.

Reset
REQ-025 SHALL, while rst_n = 0, asynchronously force state IDLE, counter 0, carry 0, y = 0, cout = 0, ovf = 0, zero = 0, out_valid = 0, in_ready = 1.
REQ-026 SHALL, on reset asserted during BUSY or DONE, abort the operation with no result delivered; first accept possible on first rising edge after rst_n deasserts.

Configuration
REQ-027 SHALL honour macro ADDSUB_SAT_EN: when defined, on ovf = 1 the presented y SHALL be saturated to 2^(W-1)-1 if a[W-1] = 0, else to -2^(W-1) (ovf still reports 1, zero computed on saturated y).
REQ-028 SHALL, when ADDSUB_SAT_EN is undefined, present the wrapped result with no saturation logic compiled in.

Verification (W=8, C=2 unless stated)
REQ-029 SHALL test a=0x7F, b=0x01, sub=0 -> y=0x80, ovf=1, cout=0, zero=0, out_valid 5 edges after accept; with ADDSUB_SAT_EN -> y=0x7F.
REQ-030 SHALL test a=0x00, b=0x01, sub=1 -> y=0xFF, cout=0, ovf=0; and a=0x05, b=0x05, sub=1 -> y=0x00, zero=1, cout=1.
REQ-031 SHALL test backpressure: out_ready=0 for 10 cycles in DONE -> y/flags stable, in_ready=0 with in_valid=1; then out_ready=1 -> IDLE next edge, new op accepted.
REQ-032 SHALL test rst_n pulsed low in mid-BUSY -> out_valid never rises for that op, all outputs 0 immediately, next op 0x10+0x20 -> y=0x30.
REQ-033 SHALL test W=16, C=16 and W=16, C=1 with random operands -> y/cout/ovf match reference model, latency 1+1 and 16+1 edges respectively.
